// File: rtl/mem_byte_sequencer.sv
// Byte sequencer between the CPU load/store port and a byte-wide single-cycle memory.
// Splits byte/half/word requests into little-endian byte accesses and assembles load data.
module mem_byte_sequencer #(
    parameter int ADDR_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              wr_q;
    logic              sgn_q;
    logic              err_q;
    logic [1:0]        size_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [31:0]       acc_q;

    logic              hs;
    logic              illegal;
    logic              last;
    logic [1:0]        last_idx;
    logic [7:0]        wbyte;
    logic [31:0]       load_ext;

    assign req_ready = (state == IDLE) & ~rst;
    assign hs        = req_valid & req_ready;

    always_comb begin
        illegal = 1'b0;
        case (req_size)
            2'b01:   illegal = ALIGN_CHECK && req_addr[0];
            2'b10:   illegal = ALIGN_CHECK && (req_addr[1:0] != 2'b00);
            2'b11:   illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    always_comb begin
        last_idx = 2'd3;
        case (size_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign last = (k_q == last_idx);

    always_comb begin
        wbyte = wdata_q[7:0];
        case (k_q)
            2'd0: wbyte = wdata_q[7:0];
            2'd1: wbyte = wdata_q[15:8];
            2'd2: wbyte = wdata_q[23:16];
            2'd3: wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    // Unfetched lanes are cleared at the handshake, so zero-extension is free.
    always_comb begin
        load_ext = acc_q;
        case (size_q)
            2'b00:   load_ext = sgn_q ? {{24{acc_q[7]}}, acc_q[7:0]}
                                      : {24'h0, acc_q[7:0]};
            2'b01:   load_ext = sgn_q ? {{16{acc_q[15]}}, acc_q[15:0]}
                                      : {16'h0, acc_q[15:0]};
            default: load_ext = acc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        case (state)
            IDLE: begin
                if (hs) state_nxt = illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_enable = 1'b1;
                mem_wr     = wr_q;
                mem_addr   = base_q + {{(ADDR_W-2){1'b0}}, k_q};
                mem_wdata  = wr_q ? wbyte : 8'h00;
                if (last) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !wr_q) resp_rdata = load_ext;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            k_q     <= 2'd0;
            base_q  <= '0;
            wdata_q <= 32'h0;
            acc_q   <= 32'h0;
        end else if (hs) begin
            wr_q    <= req_wr;
            sgn_q   <= req_signed;
            err_q   <= illegal;
            size_q  <= req_size;
            k_q     <= 2'd0;
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            acc_q   <= 32'h0;
        end else if (state == ACCESS) begin
            k_q <= k_q + 2'd1;
            if (!wr_q) begin
                case (k_q)
                    2'd0: acc_q[7:0]   <= mem_rdata;
                    2'd1: acc_q[15:8]  <= mem_rdata;
                    2'd2: acc_q[23:16] <= mem_rdata;
                    2'd3: acc_q[31:24] <= mem_rdata;
                    default: acc_q     <= acc_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: aligned-checking (u0) and unaligned (u1) instances
// sharing one byte memory, checked against a byte-array reference model.
module tb_mem_byte_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wr    [2];
    logic [1:0]  req_size  [2];
    logic        req_signed[2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        resp_valid[2];
    logic        resp_err  [2];
    logic [31:0] resp_rdata[2];
    logic        mem_enable[2];
    logic        mem_wr    [2];
    logic [31:0] mem_addr  [2];
    logic [7:0]  mem_wdata [2];
    logic [7:0]  mem_rdata [2];

    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    mem_byte_sequencer #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_err(resp_err[0]),
        .resp_rdata(resp_rdata[0]), .mem_enable(mem_enable[0]), .mem_wr(mem_wr[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_byte_sequencer #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_err(resp_err[1]),
        .resp_rdata(resp_rdata[1]), .mem_enable(mem_enable[1]), .mem_wr(mem_wr[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // 1 KiB memory; addresses alias on the low 10 bits.
    assign mem_rdata[0] = mem[mem_addr[0][9:0]];
    assign mem_rdata[1] = mem[mem_addr[1][9:0]];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (mem_enable[i] && mem_wr[i]) mem[mem_addr[i][9:0]] = mem_wdata[i];
    end

    // One request on instance d, checked cycle by cycle against the reference model.
    task automatic do_request(input int d, input logic wr, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata);
        logic        illegal;
        int          n;
        logic [31:0] exp;
        logic [31:0] a;
        illegal = (size == 2'b11) ||
                  (d == 0 && ((size == 2'b01 && addr[0]) ||
                              (size == 2'b10 && addr[1:0] != 2'b00)));
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp = 32'h0;
        if (!wr && !illegal) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                exp = exp + (32'(ref_mem[a[9:0]]) << (8 * i));
            end
            if (sgn && n < 4 && exp[8*n-1]) exp = exp - (32'h1 << (8 * n));
        end

        @(negedge clk);
        req_wr[d] = wr; req_size[d] = size; req_signed[d] = sgn;
        req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
        n_cmp++;
        if (req_ready[d] !== 1'b1) begin
            n_err++; $display("FAIL ready_idle d=%0d: got %b want 1", d, req_ready[d]);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
        req_size[d] = 2'($urandom); req_wr[d] = 1'($urandom); req_signed[d] = 1'($urandom);

        if (!illegal) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                a = addr + 32'(i);
                n_cmp++;
                if (mem_enable[d] !== 1'b1 || mem_wr[d] !== wr || mem_addr[d] !== a ||
                    resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
                    n_err++;
                    $display("FAIL access d=%0d k=%0d: got en=%b wr=%b addr=%h rv=%b rdy=%b want en=1 wr=%b addr=%h rv=0 rdy=0",
                             d, i, mem_enable[d], mem_wr[d], mem_addr[d], resp_valid[d],
                             req_ready[d], wr, a);
                end
                if (wr) begin
                    n_cmp++;
                    if (mem_wdata[d] !== wdata[8*i +: 8]) begin
                        n_err++;
                        $display("FAIL wdata d=%0d k=%0d: got %h want %h",
                                 d, i, mem_wdata[d], wdata[8*i +: 8]);
                    end
                    ref_mem[a[9:0]] = wdata[8*i +: 8];
                end
            end
        end

        @(negedge clk);
        last_rdata = resp_rdata[d];
        last_err   = resp_err[d];
        n_cmp++;
        if (resp_valid[d] !== 1'b1 || resp_err[d] !== illegal || resp_rdata[d] !== exp ||
            mem_enable[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
            n_err++;
            $display("FAIL resp d=%0d addr=%h size=%0d: got rv=%b err=%b rdata=%h en=%b rdy=%b want rv=1 err=%b rdata=%h en=0 rdy=0",
                     d, addr, size, resp_valid[d], resp_err[d], resp_rdata[d],
                     mem_enable[d], req_ready[d], illegal, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            n_err++;
            $display("FAIL after_resp d=%0d: got rv=%b rdy=%b want rv=0 rdy=1",
                     d, resp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid[0] = 1'b1; req_size[0] = 2'b10; req_addr[0] = 32'h100;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready[0] !== 1'b0 || mem_enable[0] !== 1'b0 || resp_valid[0] !== 1'b0 ||
                mem_addr[0] !== 32'h0 || resp_rdata[0] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_hold: got rdy=%b en=%b rv=%b addr=%h rdata=%h want all 0",
                         req_ready[0], mem_enable[0], resp_valid[0], mem_addr[0], resp_rdata[0]);
            end
        end
        rst = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got rdy0=%b rdy1=%b want 1 1", req_ready[0], req_ready[1]);
        end
    endtask

    task automatic test_store_word();
        logic [7:0] want [4];
        want[0] = 8'hEF; want[1] = 8'hBE; want[2] = 8'hAD; want[3] = 8'hDE;
        do_request(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[10'h100 + 10'(i)] !== want[i]) begin
                n_err++;
                $display("FAIL store_byte %0d: got %h want %h", i, mem[10'h100 + 10'(i)], want[i]);
            end
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] want [4];
        want[0] = 32'hDEADBEEF; want[1] = 32'hFFFFDEAD;
        want[2] = 32'h0000DEAD; want[3] = 32'hFFFFFFBE;
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: do_request(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
                1: do_request(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
                2: do_request(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
                default: do_request(0, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
            endcase
            n_cmp++;
            if (last_rdata !== want[t]) begin
                n_err++;
                $display("FAIL load_const %0d: got %h want %h", t, last_rdata, want[t]);
            end
        end
    endtask

    task automatic test_misaligned();
        do_request(0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        n_cmp++;
        if (last_err !== 1'b1) begin
            n_err++; $display("FAIL misaligned_err: got %b want 1", last_err);
        end
        do_request(0, 1'b1, 2'b11, 1'b0, 32'h104, 32'h12345678);
    endtask

    task automatic test_wrap_reset();
        mem[10'h3FE] = 8'h00; mem[10'h3FF] = 8'h5A; mem[10'h000] = 8'h6B; mem[10'h001] = 8'h7C;
        ref_mem[10'h3FE] = 8'h44; ref_mem[10'h3FF] = 8'h5A;
        ref_mem[10'h000] = 8'h6B; ref_mem[10'h001] = 8'h7C;
        @(negedge clk);
        req_wr[1] = 1'b1; req_size[1] = 2'b10; req_signed[1] = 1'b0;
        req_addr[1] = 32'hFFFFFFFE; req_wdata[1] = 32'h11223344; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_enable[1] !== 1'b1 || mem_wr[1] !== 1'b1 || mem_addr[1] !== 32'hFFFFFFFE ||
            mem_wdata[1] !== 8'h44) begin
            n_err++;
            $display("FAIL wrap_byte0: got en=%b wr=%b addr=%h data=%h want 1 1 fffffffe 44",
                     mem_enable[1], mem_wr[1], mem_addr[1], mem_wdata[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_addr[1] !== 32'hFFFFFFFF || mem_wdata[1] !== 8'h33) begin
            n_err++;
            $display("FAIL wrap_byte1: got addr=%h data=%h want ffffffff 33", mem_addr[1], mem_wdata[1]);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_enable[1] !== 1'b0 || mem_wr[1] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: got en=%b wr=%b want 0 0", mem_enable[1], mem_wr[1]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid[1] !== 1'b0 || mem_enable[1] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_quiet: got rv=%b en=%b want 0 0", resp_valid[1], mem_enable[1]);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
                n_err++;
                $display("FAIL post_abort: got rv=%b rdy=%b want 0 1", resp_valid[1], req_ready[1]);
            end
        end
        n_cmp++;
        if (mem[10'h3FE] !== 8'h44 || mem[10'h3FF] !== 8'h5A ||
            mem[10'h000] !== 8'h6B || mem[10'h001] !== 8'h7C) begin
            n_err++;
            $display("FAIL wrap_mem: got %h %h %h %h want 44 5a 6b 7c",
                     mem[10'h3FE], mem[10'h3FF], mem[10'h000], mem[10'h001]);
        end
    endtask

    task automatic test_random();
        int          d;
        logic [31:0] addr;
        for (int t = 0; t < 80; t++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else                           addr = 32'h200 + 32'($urandom_range(0, 127));
            do_request(d, 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom);
        end
    endtask

    task automatic test_unaligned_ok();
        do_request(1, 1'b1, 2'b10, 1'b0, 32'h281, 32'hCAFEF00D);
        do_request(1, 1'b0, 2'b01, 1'b1, 32'h283, 32'h0);
        n_cmp++;
        if (last_rdata !== 32'hFFFFCAFE) begin
            n_err++; $display("FAIL unaligned_half: got %h want ffffcafe", last_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_size[i] = 2'b00; req_signed[i] = 1'b0;
            req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
        end
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_store_word();
        test_load_ext();
        test_misaligned();
        test_wrap_reset();
        test_unaligned_ok();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
